// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the J1 code-ROM arbiter.
// The owner encoding also identifies the response pipeline state (NONE = idle).
package rom_arb_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 13;
  localparam int unsigned ARB_DATA_WIDTH = 16;
  localparam int unsigned WAIT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_WB    = 2'd2
  } owner_e;

endpackage

// File: rtl/rom_arb_starve.sv
// Starvation guard for the Wishbone port: counts consecutive denied read cycles
// and forces a Wishbone win once the count reaches MAX_WAIT (1..15).
module rom_arb_starve
  import rom_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_wb_rd_req,
  input  logic i_wb_gnt,
  output logic o_force_wb
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
  logic [WAIT_CNT_WIDTH-1:0] w_wait_nxt;

  // Count only denied reads; any grant or idle cycle restarts the streak.
  always_comb begin
    w_wait_nxt = '0;
    if (i_wb_rd_req && !i_wb_gnt) begin
      if (r_wait_cnt == WAIT_LIMIT) begin
        w_wait_nxt = r_wait_cnt;
      end else begin
        w_wait_nxt = r_wait_cnt + WAIT_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end

  assign o_force_wb = (r_wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port J1 code ROM between instruction fetch and a Wishbone
// pipelined read port; fetch has priority, bounded by a starvation guard.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic                  rom_cen,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  logic   w_wb_rd_req;
  logic   w_wb_wr_req;
  logic   w_force_wb;
  logic   w_gnt_fetch;
  logic   w_gnt_wb;
  owner_e r_owner;
  owner_e w_owner_nxt;
  logic   r_wr_err;

  assign w_wb_rd_req = wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign w_wb_wr_req = wb_cyc_i & wb_stb_i &  wb_we_i;

  rom_arb_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clock       (clock),
    .reset       (reset),
    .i_wb_rd_req (w_wb_rd_req),
    .i_wb_gnt    (w_gnt_wb),
    .o_force_wb  (w_force_wb)
  );

  // Response pipeline: owner records this cycle's grant for next cycle's data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Arbitration; a write never competes for the ROM, so fetch still wins alongside it.
  always_comb begin
    w_gnt_fetch = 1'b0;
    w_gnt_wb    = 1'b0;
    w_owner_nxt = OWN_NONE;
    if (w_wb_rd_req && (!fetch_req || w_force_wb)) begin
      w_gnt_wb    = 1'b1;
      w_owner_nxt = OWN_WB;
    end else if (fetch_req) begin
      w_gnt_fetch = 1'b1;
      w_owner_nxt = OWN_FETCH;
    end
  end

  always_comb begin
    rom_address = '0;
    if (w_gnt_wb) begin
      rom_address = wb_adr_i;
    end else if (w_gnt_fetch) begin
      rom_address = fetch_addr;
    end
  end

  assign rom_cen    = w_gnt_fetch | w_gnt_wb;
  assign fetch_gnt  = w_gnt_fetch;
  assign wb_stall_o = w_wb_rd_req & ~w_gnt_wb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wb_wr_req;
    end
  end

  // Late responses are dropped when the master has already abandoned the cycle.
  assign fetch_valid = (r_owner == OWN_FETCH);
  assign wb_ack_o    = (r_owner == OWN_WB) & wb_cyc_i;
  assign wb_err_o    = r_wr_err & wb_cyc_i;
  assign fetch_data  = rom_q;
  assign wb_dat_o    = rom_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomised + directed bench for rom_arbiter with a scoreboard and a 1-cycle ROM model.
`timescale 1ns/100ps
module tb_rom_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_stall_o;
  logic          rom_cen;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: expected fetch data, expected ack data, expected error responses.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] aq[$];
  bit            eq[$];

  // Reference model state: last cycle's winner (0 none, 1 fetch, 2 wb), its data, write flag, denied streak.
  int            m_prev;
  logic [DW-1:0] m_prev_data;
  bit            m_prev_wr;
  int            m_streak;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_cen) rom_q <= DW'({3'b000, rom_address}) ^ 16'hA5A5;
  end

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .wb_stall_o  (wb_stall_o),
    .rom_cen     (rom_cen),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'({3'b000, a}) ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    fq.delete(); aq.delete(); eq.delete();
    m_prev = 0; m_prev_data = '0; m_prev_wr = 1'b0; m_streak = 0;
  endtask

  // One clock cycle: drive inputs, predict responses and grant, check the combinational side.
  task automatic step(input logic f, input logic [AW-1:0] fa,
                      input logic c, input logic s, input logic w, input logic [AW-1:0] wa);
    bit rd, wr, gw, gf;
    logic [AW-1:0] ea;
    @(posedge clock); #1;
    fetch_req = f; fetch_addr = fa;
    wb_cyc_i = c; wb_stb_i = s; wb_we_i = w; wb_adr_i = wa;
    if (m_prev == 1) fq.push_back(m_prev_data);
    if (m_prev == 2 && c) aq.push_back(m_prev_data);
    if (m_prev_wr && c) eq.push_back(1'b1);
    rd = c && s && !w;
    wr = c && s && w;
    gw = rd && (!f || m_streak == int'(MW));
    gf = f && !gw;
    ea = gw ? wa : (gf ? fa : '0);
    if (rd && !gw) m_streak = (m_streak < int'(MW)) ? m_streak + 1 : int'(MW);
    else           m_streak = 0;
    m_prev      = gw ? 2 : (gf ? 1 : 0);
    m_prev_data = rom_word(ea);
    m_prev_wr   = wr;
    #2;
    chk("fetch_gnt",   32'(fetch_gnt),   32'(gf));
    chk("wb_stall",    32'(wb_stall_o),  32'(rd && !gw));
    chk("rom_cen",     32'(rom_cen),     32'(gf || gw));
    chk("rom_address", 32'(rom_address), 32'(ea));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: every cycle, the presence and content of each response must match the scoreboard.
  task automatic monitor();
    logic [DW-1:0] d;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("fetch_valid", 32'(fetch_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
          d = fq.pop_front();
          if (fetch_valid) chk("fetch_data", 32'(fetch_data), 32'(d));
        end
        chk("wb_ack", 32'(wb_ack_o), 32'(aq.size() != 0));
        if (aq.size() != 0) begin
          d = aq.pop_front();
          if (wb_ack_o) chk("wb_dat", 32'(wb_dat_o), 32'(d));
        end
        chk("wb_err", 32'(wb_err_o), 32'(eq.size() != 0));
        if (eq.size() != 0) void'(eq.pop_front());
      end
    end
  endtask

  task automatic reset_mid();
    step(1'b1, 13'h0040, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 13'h0041, 1'b0, 1'b0, 1'b0, '0);
    chk("fetch_valid_pre_reset", 32'(fetch_valid), 32'd1);
    #1 reset = 1'b1;
    #0.5;
    chk("fetch_valid_async_reset", 32'(fetch_valid), 32'd0);
    chk("rom_cen_in_reset", 32'(rom_cen), 32'd1);
    model_clear();
    fetch_req = 1'b0;
    @(posedge clock); #2;
    chk("fetch_valid_held_reset", 32'(fetch_valid), 32'd0);
    reset = 1'b0;
  endtask

  task automatic driver();
    logic f, c, s, w;
    // Reset state with all requesters idle.
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #2;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_wb_ack",      32'(wb_ack_o),    32'd0);
    chk("rst_wb_err",      32'(wb_err_o),    32'd0);
    chk("rst_rom_cen",     32'(rom_cen),     32'd0);
    reset = 1'b0;

    // Fetch only, same address three times.
    for (int i = 0; i < 3; i++) step(1'b1, 13'h0010, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    // Single Wishbone read at the top of the code space.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 13'h1FFF);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);
    // Contention: WB wins on its fifth cycle, then again after a fresh streak.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 13'h0010, 1'b1, 1'b1, 1'b0, 13'h0200 + AW'(r));
      step(1'b1, 13'h0011, 1'b1, 1'b0, 1'b0, '0);
      idle(1);
    end
    // Cycle abort right after a WB grant.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 13'h0123);
    idle(3);
    // Write attempts, alone and alongside a fetch.
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 13'h0055);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 13'h0077, 1'b1, 1'b1, 1'b1, 13'h0055);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    // Asynchronous reset while a fetch response is on the outputs.
    reset_mid();
    step(1'b1, 13'h0042, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    // Random traffic.
    c = 1'b0;
    for (int i = 0; i < 400; i++) begin
      f = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 15) c = ~c;
      s = c && ($urandom_range(0, 99) < 70);
      w = ($urandom_range(0, 99) < 10);
      step(f, AW'($urandom), c, s, w, AW'($urandom));
    end
    idle(3);
    @(negedge clock); #1;
  endtask

  initial begin
    fork
      driver();
      monitor();
    join_any
    disable fork;
    if (fq.size() != 0 || aq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses still expected", fq.size() + aq.size() + eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
